// File: rtl/fetch_stage_if.sv
// Bundle of the instruction-memory handshake, downstream control and the IF/ID
// register outputs of the LC-3b fetch stage.
interface fetch_stage_if;
   logic        imem_read;
   logic [15:0] imem_address;
   logic        imem_resp;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        ifid_valid;
   logic [15:0] ifid_pc;
   logic [15:0] ifid_pc_plus2;
   logic [15:0] ifid_ir;

   modport master (
      output imem_read, imem_address,
      output ifid_valid, ifid_pc, ifid_pc_plus2, ifid_ir,
      input  imem_resp, imem_rdata, stall, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_read, imem_address,
      input  ifid_valid, ifid_pc, ifid_pc_plus2, ifid_ir,
      output imem_resp, imem_rdata, stall, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, runs the imem read handshake,
// buffers one instruction across ID stalls and squashes fetches on redirect.
module fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {FETCH, HOLD, KILL} state_t;

   state_t      state;
   logic [15:0] pc;
   logic [15:0] req_addr;
   logic [15:0] hold_pc;
   logic [15:0] hold_ir;
   logic        valid_q;
   logic [15:0] ifid_pc_q;
   logic [15:0] ifid_pc_plus2_q;
   logic [15:0] ifid_ir_q;

   logic [15:0] pc_plus2;
   logic [15:0] hold_pc_plus2;

   assign pc_plus2      = pc + 16'd2;
   assign hold_pc_plus2 = hold_pc + 16'd2;

   // KILL keeps presenting the squashed request's address until its response drains.
   assign bus.imem_read     = rst_n && (state != HOLD);
   assign bus.imem_address  = (state == KILL) ? req_addr : pc;
   assign bus.ifid_valid    = valid_q;
   assign bus.ifid_pc       = ifid_pc_q;
   assign bus.ifid_pc_plus2 = ifid_pc_plus2_q;
   assign bus.ifid_ir       = ifid_ir_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= FETCH;
         pc              <= RESET_PC;
         req_addr        <= RESET_PC;
         hold_pc         <= 16'h0000;
         hold_ir         <= NOP_INSTR;
         valid_q         <= 1'b0;
         ifid_pc_q       <= 16'h0000;
         ifid_pc_plus2_q <= 16'h0000;
         ifid_ir_q       <= NOP_INSTR;
      end else begin
         if (state == FETCH)
            req_addr <= pc;

         if (bus.redirect_valid) begin
            // Redirect wins over stall; an unanswered FETCH request must be drained in KILL.
            pc        <= bus.redirect_pc & 16'hFFFE;
            valid_q   <= 1'b0;
            ifid_ir_q <= NOP_INSTR;
            case (state)
               FETCH:   state <= bus.imem_resp ? FETCH : KILL;
               HOLD:    state <= FETCH;
               KILL:    state <= bus.imem_resp ? FETCH : KILL;
               default: state <= FETCH;
            endcase
         end else begin
            case (state)
               FETCH: begin
                  if (bus.imem_resp) begin
                     if (!bus.stall) begin
                        valid_q         <= 1'b1;
                        ifid_pc_q       <= pc;
                        ifid_pc_plus2_q <= pc_plus2;
                        ifid_ir_q       <= bus.imem_rdata;
                        pc              <= pc_plus2;
                     end else begin
                        hold_ir <= bus.imem_rdata;
                        hold_pc <= pc;
                        state   <= HOLD;
                     end
                  end else if (!bus.stall) begin
                     valid_q   <= 1'b0;
                     ifid_ir_q <= NOP_INSTR;
                  end
               end
               HOLD: begin
                  if (!bus.stall) begin
                     valid_q         <= 1'b1;
                     ifid_pc_q       <= hold_pc;
                     ifid_pc_plus2_q <= hold_pc_plus2;
                     ifid_ir_q       <= hold_ir;
                     pc              <= pc_plus2;
                     state           <= FETCH;
                  end
               end
               KILL: begin
                  if (bus.imem_resp)
                     state <= FETCH;
                  if (!bus.stall) begin
                     valid_q   <= 1'b0;
                     ifid_ir_q <= NOP_INSTR;
                  end
               end
               default: state <= FETCH;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step drives one cycle of memory/control
// inputs and then checks the IF/ID register and imem request against hand values.
module tb_fetch_stage;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   fetch_stage_if fif ();

   fetch_stage #(
      .RESET_PC (16'h0000),
      .NOP_INSTR(16'h0000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (fif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
   task automatic applyStimulus(input logic resp, input logic [15:0] rdata,
                                input logic stl, input logic rv, input logic [15:0] rpc);
      fif.imem_resp      = resp;
      fif.imem_rdata     = rdata;
      fif.stall          = stl;
      fif.redirect_valid = rv;
      fif.redirect_pc    = rpc;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkImem(input string tag, input logic rd, input logic [15:0] addr);
      checkOutput({tag, ".imem_read"}, {15'b0, fif.imem_read}, {15'b0, rd});
      if (rd)
         checkOutput({tag, ".imem_address"}, fif.imem_address, addr);
   endtask

   task automatic checkIfid(input string tag, input logic v, input logic [15:0] pc,
                            input logic [15:0] pc2, input logic [15:0] ir);
      checkOutput({tag, ".ifid_valid"}, {15'b0, fif.ifid_valid}, {15'b0, v});
      checkOutput({tag, ".ifid_pc"}, fif.ifid_pc, pc);
      checkOutput({tag, ".ifid_pc_plus2"}, fif.ifid_pc_plus2, pc2);
      checkOutput({tag, ".ifid_ir"}, fif.ifid_ir, ir);
   endtask

   initial begin
      compared           = 0;
      mismatched         = 0;
      rst_n              = 1'b0;
      fif.imem_resp      = 1'b0;
      fif.imem_rdata     = 16'h0000;
      fif.stall          = 1'b0;
      fif.redirect_valid = 1'b0;
      fif.redirect_pc    = 16'h0000;

      #12;
      checkImem("reset", 1'b0, 16'h0000);
      checkIfid("reset", 1'b0, 16'h0000, 16'h0000, 16'h0000);
      rst_n = 1'b1;
      #1;
      checkImem("post_reset", 1'b1, 16'h0000);

      // 1-cycle memory: two instructions with bubbles in between.
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      checkImem("wait0", 1'b1, 16'h0000);
      checkIfid("wait0", 1'b0, 16'h0000, 16'h0000, 16'h0000);
      applyStimulus(1'b1, 16'h1261, 1'b0, 1'b0, 16'h0000);
      checkIfid("acc0", 1'b1, 16'h0000, 16'h0002, 16'h1261);
      checkImem("acc0", 1'b1, 16'h0002);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      checkIfid("bub1", 1'b0, 16'h0000, 16'h0002, 16'h0000);
      applyStimulus(1'b1, 16'h5020, 1'b0, 1'b0, 16'h0000);
      checkIfid("acc2", 1'b1, 16'h0002, 16'h0004, 16'h5020);
      checkImem("acc2", 1'b1, 16'h0004);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      checkIfid("bub2", 1'b0, 16'h0002, 16'h0004, 16'h0000);

      // Stall during the response for 0x0004, held three cycles.
      applyStimulus(1'b1, 16'hA0C1, 1'b1, 1'b0, 16'h0000);
      checkImem("hold1", 1'b0, 16'h0000);
      checkIfid("hold1", 1'b0, 16'h0002, 16'h0004, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      checkImem("hold2", 1'b0, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      checkImem("hold3", 1'b0, 16'h0000);
      checkIfid("hold3", 1'b0, 16'h0002, 16'h0004, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      checkIfid("release", 1'b1, 16'h0004, 16'h0006, 16'hA0C1);
      checkImem("release", 1'b1, 16'h0006);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 16'h1DA0, 1'b0, 1'b0, 16'h0000);
      checkIfid("acc6", 1'b1, 16'h0006, 16'h0008, 16'h1DA0);
      checkImem("acc6", 1'b1, 16'h0008);

      // Redirect to 0x0041 while the 3-cycle read at 0x0008 is outstanding.
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0041);
      checkImem("kill1", 1'b1, 16'h0008);
      checkIfid("kill1", 1'b0, 16'h0006, 16'h0008, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      checkImem("kill2", 1'b1, 16'h0008);
      checkOutput("kill2.ifid_valid", {15'b0, fif.ifid_valid}, 16'h0000);
      applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000);
      checkImem("kill_done", 1'b1, 16'h0040);
      checkIfid("kill_done", 1'b0, 16'h0006, 16'h0008, 16'h0000);

      // Redirect to 0x0100 while an instruction sits in the hold buffer.
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0, 16'h0000);
      checkImem("hold40", 1'b0, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100);
      checkImem("hold_redir", 1'b1, 16'h0100);
      checkIfid("hold_redir", 1'b0, 16'h0006, 16'h0008, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      checkIfid("no_stale", 1'b0, 16'h0006, 16'h0008, 16'h0000);

      // Redirect coinciding with resp and stall in FETCH.
      applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, 16'h0100);
      checkImem("fetch_redir", 1'b1, 16'h0100);
      checkIfid("fetch_redir", 1'b0, 16'h0006, 16'h0008, 16'h0000);
      applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
      checkIfid("acc100", 1'b1, 16'h0100, 16'h0102, 16'h2222);
      checkImem("acc100", 1'b1, 16'h0102);

      // Odd target is aligned; PC wraps from 0xFFFE to 0x0000.
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
      checkImem("wrap_kill", 1'b1, 16'h0102);
      applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
      checkImem("wrap_fetch", 1'b1, 16'hFFFE);
      applyStimulus(1'b1, 16'h0E03, 1'b0, 1'b0, 16'h0000);
      checkIfid("wrap", 1'b1, 16'hFFFE, 16'h0000, 16'h0E03);
      checkImem("wrap", 1'b1, 16'h0000);

      // Reset dropped in the middle of a request at 0x0010.
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010);
      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
      checkImem("pre_rst", 1'b1, 16'h0010);
      fif.imem_resp = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkImem("mid_rst", 1'b0, 16'h0000);
      checkIfid("mid_rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkImem("restart", 1'b1, 16'h0000);
      checkOutput("restart.ifid_valid", {15'b0, fif.ifid_valid}, 16'h0000);
      applyStimulus(1'b1, 16'h1261, 1'b0, 1'b0, 16'h0000);
      checkIfid("restart_acc", 1'b1, 16'h0000, 16'h0002, 16'h1261);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
